// File: rtl/alu_isa_pkg.sv
// ISA definitions shared by the issue stage: opcode encoding, instruction
// field positions and opcode classification helpers.
package alu_isa_pkg;

  localparam int OPC_W     = 4;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 8;
  localparam int CONST_W   = 2;
  localparam int INSTR_W   = 9;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 2;
  localparam int LO_MSB  = 1;
  localparam int LO_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUB  = 4'd2,
    OP_SHL  = 4'd3,
    OP_SLT  = 4'd4,
    OP_EQ0  = 4'd5,
    OP_CMP4 = 4'd6,
    OP_XOR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_NOT  = 4'd10
  } opcode_e;

  // Opcodes above OP_NOT are decoded as NOPs that never write back.
  function automatic logic is_writing(input logic [OPC_W-1:0] op);
    return op <= OP_NOT;
  endfunction

  function automatic logic uses_constant(input logic [OPC_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x8 register file: one synchronous write port, two combinational read
// ports and a combinational debug read port (all reads are pre-write).
module alu_regfile
  import alu_isa_pkg::*;
#(
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  output logic [DATA_W-1:0]    o_rdata1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]    o_rdata2,
  input  logic [REG_IDX_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0]    o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1   = r_mem[i_raddr1];
  assign o_rdata2   = r_mem[i_raddr2];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: decodes, reads operands with bypass from
// the in-flight result, holds a one-entry EX register and performs writeback.
module alu_issue_stage
  import alu_isa_pkg::*;
#(
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 instr_ready,
  input  logic                 stall,
  output logic                 ex_valid,
  output logic [OPC_W-1:0]     ex_opcode,
  output logic [DATA_W-1:0]    ex_rs1,
  output logic [DATA_W-1:0]    ex_rs2,
  output logic [CONST_W-1:0]   ex_constant,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_overflow,
  output logic                 ovf_flag,
  output logic                 illegal,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  // Handshake: an instruction is taken on any rising edge where
  // instr_valid & instr_ready; instr_ready is simply ~stall.
  logic                 r_ex_valid;
  logic [OPC_W-1:0]     r_ex_opcode;
  logic [REG_IDX_W-1:0] r_ex_rd;
  logic [DATA_W-1:0]    r_ex_rs1;
  logic [DATA_W-1:0]    r_ex_rs2;
  logic [CONST_W-1:0]   r_ex_constant;
  logic                 r_ovf_flag;
  logic                 r_illegal;

  logic [OPC_W-1:0]     w_opcode;
  logic [REG_IDX_W-1:0] w_rs1_idx;
  logic [REG_IDX_W-1:0] w_rs2_idx;
  logic [CONST_W-1:0]   w_constant;
  logic [DATA_W-1:0]    w_rf_rs1;
  logic [DATA_W-1:0]    w_rf_rs2;
  logic [DATA_W-1:0]    w_op1;
  logic [DATA_W-1:0]    w_op2;
  logic                 w_accept;
  logic                 w_wb;

  assign w_opcode   = instr[OPC_MSB:OPC_LSB];
  assign w_rs1_idx  = instr[RD_MSB:RD_LSB];
  assign w_rs2_idx  = {1'b0, instr[LO_MSB:LO_LSB]};
  assign w_constant = uses_constant(w_opcode) ? instr[LO_MSB:LO_LSB] : '0;

  assign instr_ready = ~stall;
  assign w_accept    = instr_valid & ~stall;
  assign w_wb        = r_ex_valid & ~stall & is_writing(r_ex_opcode);

  alu_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_wb),
    .i_waddr    (r_ex_rd),
    .i_wdata    (alu_result),
    .i_raddr1   (w_rs1_idx),
    .o_rdata1   (w_rf_rs1),
    .i_raddr2   (w_rs2_idx),
    .o_rdata2   (w_rf_rs2),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Result being retired this cycle overrides the stale regfile read.
  assign w_op1 = (w_wb && (w_rs1_idx == r_ex_rd)) ? alu_result : w_rf_rs1;
  assign w_op2 = (w_wb && (w_rs2_idx == r_ex_rd)) ? alu_result : w_rf_rs2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_opcode   <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_constant <= '0;
      r_ovf_flag    <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      if (w_wb && (r_ex_opcode == OP_ADD)) r_ovf_flag <= r_ovf_flag | alu_overflow;
      if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_opcode   <= w_opcode;
        r_ex_rd       <= w_rs1_idx;
        r_ex_rs1      <= w_op1;
        r_ex_rs2      <= w_op2;
        r_ex_constant <= w_constant;
        if (!is_writing(w_opcode)) r_illegal <= 1'b1;
      end else if (!stall) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_opcode   = r_ex_opcode;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_constant = r_ex_constant;
  assign ovf_flag    = r_ovf_flag;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked against an architectural model of registers and the in-flight op.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic       stall;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [7:0] ex_rs1;
  logic [7:0] ex_rs2;
  logic [1:0] ex_constant;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       ovf_flag;
  logic       illegal;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_constant  (ex_constant),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .ovf_flag     (ovf_flag),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model: register contents plus the one instruction in flight.
  logic [7:0] m_regs [8];
  logic       m_v;
  logic [3:0] m_op;
  logic [2:0] m_rd;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [1:0] m_c;
  logic       m_ovf;
  logic       m_ill;

  logic       ovr_en  = 1'b0;
  logic [7:0] ovr_res = 8'h00;
  logic       ovr_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int op, input int rd, input int lo);
    logic [8:0] w;
    w = {op[3:0], rd[2:0], lo[1:0]};
    return w;
  endfunction

  // Stand-in ALU; returns {overflow, result}. Overflow is unsigned carry of ADD.
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [1:0] c);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a + {6'b0, c}};
      4'd2:    return {1'b0, a - b};
      4'd3:    return {1'b0, a << c};
      4'd4:    return {8'b0, (a < b)};
      4'd5:    return {8'b0, (a == 8'h00)};
      4'd6:    return {1'b0, a ^ 8'h44};
      4'd7:    return {1'b0, a ^ b};
      4'd8:    return {1'b0, a & b};
      4'd9:    return {1'b0, a | b};
      4'd10:   return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  task automatic peek(input int a, input string tag, input logic [7:0] exp);
    dbg_addr = a[2:0];
    #1;
    check(tag, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance model, check post-edge.
  task automatic cycle(input logic iv, input logic [8:0] ins, input logic st, input logic rst);
    logic [8:0] ar;
    logic [7:0] nregs [8];
    logic       wb;
    instr_valid = iv;
    instr       = ins;
    stall       = st;
    reset       = rst;
    dbg_addr    = 3'($urandom_range(0, 7));
    ar = alu_ref(m_op, m_a, m_b, m_c);
    if (ovr_en) ar = {ovr_ovf, ovr_res};
    alu_result   = ar[7:0];
    alu_overflow = ar[8];
    #1;
    check("ready", {31'b0, instr_ready}, {31'b0, ~st});
    if (!rst) check("dbg", {24'b0, dbg_data}, {24'b0, m_regs[dbg_addr]});

    nregs = m_regs;
    wb = m_v && !st && (m_op <= 4'd10);
    if (wb) nregs[m_rd] = ar[7:0];
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_v = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_c = 0; m_ovf = 0; m_ill = 0;
    end else begin
      if (wb && m_op == 4'd0) m_ovf = m_ovf | ar[8];
      if (!st) begin
        if (iv) begin
          m_v  = 1'b1;
          m_op = ins[8:5];
          m_rd = ins[4:2];
          m_a  = nregs[ins[4:2]];
          m_b  = nregs[{1'b0, ins[1:0]}];
          m_c  = (m_op == 4'd1 || m_op == 4'd3) ? ins[1:0] : 2'b00;
          if (m_op > 4'd10) m_ill = 1'b1;
        end else begin
          m_v = 1'b0;
        end
      end
      m_regs = nregs;
    end

    @(posedge clk);
    @(negedge clk);
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m_v});
    check("ex_opcode", {28'b0, ex_opcode}, {28'b0, m_op});
    check("ex_rs1", {24'b0, ex_rs1}, {24'b0, m_a});
    if (m_op == 4'd1 || m_op == 4'd3) check("ex_constant", {30'b0, ex_constant}, {30'b0, m_c});
    else check("ex_rs2", {24'b0, ex_rs2}, {24'b0, m_b});
    check("ovf_flag", {31'b0, ovf_flag}, {31'b0, m_ovf});
    check("illegal", {31'b0, illegal}, {31'b0, m_ill});
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0;
    alu_result = '0; alu_overflow = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_v = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_c = 0; m_ovf = 0; m_ill = 0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, 9'h0, 1'b0, 1'b1);
    cycle(1'b0, 9'h0, 1'b0, 1'b1);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ex_fields", {10'b0, ex_opcode, ex_rs1, ex_rs2, ex_constant}, 32'd0);
    check("rst_flags", {30'b0, ovf_flag, illegal}, 32'd0);
    for (int r = 0; r < 8; r++) peek(r, "rst_reg", 8'h00);

    // ADDI r1,3
    cycle(1'b1, mk(1, 1, 3), 1'b0, 1'b0);
    check("addi_opc", {28'b0, ex_opcode}, 32'd1);
    check("addi_const", {30'b0, ex_constant}, 32'd3);
    check("addi_rs1", {24'b0, ex_rs1}, 32'd0);
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    peek(1, "addi_r1", 8'h03);

    // Back-to-back dependency through bypass
    cycle(1'b0, 9'h0, 1'b0, 1'b1);
    cycle(1'b1, mk(1, 1, 3), 1'b0, 1'b0);
    cycle(1'b1, mk(0, 1, 1), 1'b0, 1'b0);
    check("byp_rs1", {24'b0, ex_rs1}, 32'h03);
    check("byp_rs2", {24'b0, ex_rs2}, 32'h03);
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    peek(1, "byp_r1", 8'h06);

    // Overflowing ADD sets the sticky flag
    cycle(1'b1, mk(1, 2, 0), 1'b0, 1'b0);
    ovr_en = 1'b1; ovr_res = 8'hF0; ovr_ovf = 1'b0;
    cycle(1'b1, mk(1, 3, 0), 1'b0, 1'b0);
    ovr_res = 8'h20;
    cycle(1'b1, mk(0, 2, 3), 1'b0, 1'b0);
    ovr_en = 1'b0;
    check("ovf_rs1", {24'b0, ex_rs1}, 32'hF0);
    check("ovf_rs2", {24'b0, ex_rs2}, 32'h20);
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    peek(2, "ovf_r2", 8'h10);
    check("ovf_set", {31'b0, ovf_flag}, 32'd1);
    cycle(1'b1, mk(0, 5, 0), 1'b0, 1'b0);
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    check("ovf_sticky", {31'b0, ovf_flag}, 32'd1);

    // Stall holds EX and defers writeback
    cycle(1'b1, mk(1, 4, 1), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, mk(2, 4, 0), 1'b1, 1'b0);
      check("stall_hold_opc", {28'b0, ex_opcode}, 32'd1);
      peek(4, "stall_r4", 8'h00);
    end
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    peek(4, "unstall_r4", 8'h01);
    ovr_en = 1'b1; ovr_res = 8'h77; ovr_ovf = 1'b0;
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    ovr_en = 1'b0;
    peek(4, "once_r4", 8'h01);

    // Illegal opcode, then reset during a stall
    cycle(1'b1, mk(12, 6, 1), 1'b0, 1'b0);
    cycle(1'b0, 9'h0, 1'b0, 1'b0);
    check("illegal_set", {31'b0, illegal}, 32'd1);
    peek(6, "illegal_r6", 8'h00);
    cycle(1'b1, mk(1, 7, 2), 1'b0, 1'b0);
    cycle(1'b0, 9'h0, 1'b1, 1'b0);
    cycle(1'b0, 9'h0, 1'b1, 1'b1);
    check("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_stall_ill", {31'b0, illegal}, 32'd0);
    peek(2, "rst_stall_r2", 8'h00);
    peek(7, "rst_stall_r7", 8'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ovr_en  = ($urandom_range(0, 3) == 0);
      ovr_res = 8'($urandom);
      ovr_ovf = 1'($urandom);
      cycle(($urandom_range(0, 9) < 7), 9'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) == 0));
    end
    ovr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the 8-bit ALU.
- Accepts 9-bit instructions and decodes opcode, register indices and 2-bit constant.
- Reads an 8x8 register file with bypass and drives a registered ID/EX bundle into the ALU.
- Writes the ALU result back and keeps a sticky overflow flag from add.

Parameters:
- NUM_REGS, 8, register file depth (index width 3 bits; fixed by the instruction format).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  upstream instruction present.
- instr  input  9  instruction word.
- instr_ready  output  1  stage accepts instr this cycle; equals ~stall.
- stall  input  1  downstream hold; freezes EX bundle and suppresses writeback.
- ex_valid  output  1  EX bundle valid.
- ex_opcode  output  4  to ALU opcode.
- ex_rs1  output  8  to ALU first operand.
- ex_rs2  output  8  to ALU second operand.
- ex_constant  output  2  to ALU constant.
- alu_result  input  8  ALU output for the current EX bundle (combinational return).
- alu_overflow  input  1  ALU overflow for the current EX bundle.
- ovf_flag  output  1  sticky overflow flag.
- illegal  output  1  sticky flag: an opcode of 4'b1011–4'b1111 was accepted.
- dbg_addr  input  3  debug read index.
- dbg_data  output  8  register-file contents at dbg_addr (combinational, pre-writeback).

Behaviour:
- Format: instr[8:5]=opcode; instr[4:2]=rd, which is also the rs1 index; instr[1:0]=constant for addi (0001) and shl (0011).
- For all other opcodes, instr[1:0] is the rs2 index, zero-extended to 3 bits (r0..r3 only).
- Writing opcodes: 0000–1010. Opcodes 1011–1111 are NOPs: ex_valid=1, no writeback, illegal set to 1.
- Reset: all registers=RESET_VAL; ex_valid=0; ex_opcode/ex_rs1/ex_rs2/ex_constant=0; ovf_flag=0; illegal=0. Reset overrides stall and any pending writeback.
- Accept: on a cycle with instr_valid & ~stall, the EX bundle loads the decoded instruction and ex_valid<=1. ex_rd is held internally.
- With ~instr_valid & ~stall, ex_valid<=0 and the other EX fields hold.
- With stall=1, every EX field holds and nothing is written.
- Latency: instruction accepted in cycle N is presented to the ALU in N+1 and written back at the end of N+1 (if ~stall in N+1).
- Writeback:
  - On ex_valid & ~stall & writing opcode, regfile[ex_rd]<=alu_result.
  - If ex_opcode==0000, ovf_flag<=ovf_flag|alu_overflow.
  - A stalled EX instruction writes back only on the cycle stall drops, exactly once.
- Bypass: when decoding in a cycle where writeback occurs, a source index equal to ex_rd takes alu_result instead of the regfile value. This applies to rs1 and rs2 independently. Back-to-back dependent instructions need no bubbles.
- Write-then-read of the same index in one cycle is covered by the bypass. dbg_data shows the pre-write value.
- No FSM beyond the single valid bit. The stage is a 1-entry pipeline register with hold.
- Arithmetic: none in this block; all arithmetic is in the ALU. Widths are passed through unchanged.

Decomposition:
- Package alu_isa_pkg:
  - opcode enum: ADD, ADDI, SUB, SHL, SLT, EQ0, CMP4, XOR, AND, OR, NOT.
  - Instruction field positions, OPC_W=4, REG_IDX_W=3.
  - Function is_writing(opcode) and function uses_constant(opcode).
- Sub-module alu_regfile: 8x8, synchronous write port, two combinational read ports, plus the debug read port.
- Bypass muxes and the EX register stay in the top level.

Test Plan:
- Reset, then dbg reads of r0..r7 -> all 8'h00; ex_valid=0; ovf_flag=0; illegal=0.
- Accept ADDI r1,c=3, with the ALU model returning 8'h03 -> next cycle ex_opcode=0001, ex_constant=2'b11, ex_rs1=0; afterwards dbg r1=8'h03.
- Back-to-back ADDI r1,3 then ADD r1,r1 (rs2 idx 1) -> second bundle has ex_rs1=ex_rs2=8'h03 via bypass; r1 becomes 8'h06.
- r2=8'hF0 and r3=8'h20, then ADD r2,r3 with ALU returning 8'h10/ovf=1 -> r2=8'h10, ovf_flag=1. A later non-overflowing ADD leaves ovf_flag=1.
- stall held 3 cycles during ADDI r4,1 -> instr_ready=0 and EX holds; r4 is unchanged until stall drops, then written exactly once (8'h01).
- Opcode 4'b1100 accepted -> illegal=1, no register changes; reset mid-stall clears ex_valid, illegal and the regfile.
